// File: rtl/multicycle_ctr_pkg.sv
// rtl/multicycle_ctr_pkg.sv - opcodes, state encodings, control codes and control vector for the multi-cycle controller
package multicycle_ctr_pkg;

    // Instruction opcodes (IR[31:26])
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    // ALU operation select
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // ALU B operand select
    localparam logic [1:0] SRCB_RT     = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_BRADDR = 2'b11;

    // PC source select
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_MEMADR = 4'd3,
        S_MEMRD  = 4'd4,
        S_MEMWB  = 4'd5,
        S_MEMWR  = 4'd6,
        S_EXEC   = 4'd7,
        S_RWB    = 4'd8,
        S_ADDIWB = 4'd9,
        S_BRANCH = 4'd10,
        S_JUMP   = 4'd11
    } state_e;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       ior_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
        logic       inst_retired;
    } ctrl_t;

    // States that stall on the memory handshake and run the wait counter
    function automatic logic is_wait_state(input state_e s);
        return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
    endfunction

endpackage

// File: rtl/multicycle_ctr_outdec.sv
// rtl/multicycle_ctr_outdec.sv - combinational state to ungated control vector decode
module multicycle_ctr_outdec
    import multicycle_ctr_pkg::*;
(
    input  state_e state_i,
    output ctrl_t  ctrl_o
);

    // Moore decode; FETCH write enables and MEMWR retire are qualified by memReady in the top
    always_comb begin
        ctrl_o = '0;
        case (state_i)
            S_FETCH: begin
                ctrl_o.mem_read  = 1'b1;
                ctrl_o.alu_src_b = SRCB_FOUR;
                ctrl_o.ir_write  = 1'b1;
                ctrl_o.pc_write  = 1'b1;
            end
            S_DECODE: begin
                ctrl_o.alu_src_b = SRCB_BRADDR;
            end
            S_MEMADR: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = SRCB_IMM;
            end
            S_MEMRD: begin
                ctrl_o.mem_read = 1'b1;
                ctrl_o.ior_d    = 1'b1;
            end
            S_MEMWB: begin
                ctrl_o.reg_write    = 1'b1;
                ctrl_o.mem_to_reg   = 1'b1;
                ctrl_o.inst_retired = 1'b1;
            end
            S_MEMWR: begin
                ctrl_o.mem_write    = 1'b1;
                ctrl_o.ior_d        = 1'b1;
                ctrl_o.inst_retired = 1'b1;
            end
            S_EXEC: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_op    = ALUOP_FUNCT;
            end
            S_RWB: begin
                ctrl_o.reg_write    = 1'b1;
                ctrl_o.reg_dst      = 1'b1;
                ctrl_o.inst_retired = 1'b1;
            end
            S_ADDIWB: begin
                ctrl_o.reg_write    = 1'b1;
                ctrl_o.inst_retired = 1'b1;
            end
            S_BRANCH: begin
                ctrl_o.alu_src_a     = 1'b1;
                ctrl_o.alu_op        = ALUOP_SUB;
                ctrl_o.pc_write_cond = 1'b1;
                ctrl_o.pc_source     = PCSRC_ALUOUT;
                ctrl_o.inst_retired  = 1'b1;
            end
            S_JUMP: begin
                ctrl_o.pc_write     = 1'b1;
                ctrl_o.pc_source    = PCSRC_JUMP;
                ctrl_o.inst_retired = 1'b1;
            end
            default: ctrl_o = '0;
        endcase
    end

endmodule

// File: rtl/multicycle_ctr.sv
// rtl/multicycle_ctr.sv - multi-cycle MIPS control FSM with memory wait and timeout abort
module multicycle_ctr
    import multicycle_ctr_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opCode,
    input  logic       zero,
    input  logic       memReady,
    output logic       pcWrite,
    output logic       pcWriteCond,
    output logic       iorD,
    output logic       memRead,
    output logic       memWrite,
    output logic       irWrite,
    output logic       memToReg,
    output logic       regDst,
    output logic       regWrite,
    output logic       aluSrcA,
    output logic [1:0] aluSrcB,
    output logic [1:0] aluOp,
    output logic [1:0] pcSource,
    output logic       instRetired,
    output logic       illegalOp,
    output logic       memTimeout,
    output logic [3:0] state
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             timeout_hit;
    logic             illegal;
    ctrl_t            base_ctrl;
    ctrl_t            ctrl;

    // zero is consumed by the datapath through pcWriteCond, not by the sequencer
    logic unused_zero;
    assign unused_zero = zero;

    multicycle_ctr_outdec u_outdec (
        .state_i (state_q),
        .ctrl_o  (base_ctrl)
    );

    // A wait aborts on its last allowed cycle unless memory completes in that same cycle
    assign timeout_hit = (TIMEOUT != 0) && is_wait_state(state_q) && !memReady && (cnt_q == CNT_LAST);

    // State and wait counter registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state sequencing per opcode, plus illegal-opcode flag in DECODE
    always_comb begin
        state_d = state_q;
        illegal = 1'b0;
        case (state_q)
            S_IDLE:   state_d = S_FETCH;
            S_FETCH: begin
                if (memReady)         state_d = S_DECODE;
                else if (timeout_hit) state_d = S_FETCH;
            end
            S_DECODE: begin
                case (opCode)
                    OP_RTYPE:                state_d = S_EXEC;
                    OP_LW, OP_SW, OP_ADDI:   state_d = S_MEMADR;
                    OP_BEQ:                  state_d = S_BRANCH;
                    OP_J:                    state_d = S_JUMP;
                    default: begin
                        illegal = 1'b1;
                        state_d = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                case (opCode)
                    OP_LW:   state_d = S_MEMRD;
                    OP_SW:   state_d = S_MEMWR;
                    OP_ADDI: state_d = S_ADDIWB;
                    default: state_d = S_FETCH;
                endcase
            end
            S_MEMRD: begin
                if (memReady)         state_d = S_MEMWB;
                else if (timeout_hit) state_d = S_FETCH;
            end
            S_MEMWR: begin
                if (memReady || timeout_hit) state_d = S_FETCH;
            end
            S_EXEC:   state_d = S_RWB;
            S_MEMWB, S_RWB, S_ADDIWB, S_BRANCH, S_JUMP: state_d = S_FETCH;
            default:  state_d = S_IDLE;
        endcase
    end

    // Counter restarts on every state entry (including timeout re-entry of FETCH) and saturates
    always_comb begin
        cnt_d = cnt_q;
        if (timeout_hit || (state_d != state_q)) begin
            cnt_d = '0;
        end else if (is_wait_state(state_q) && !memReady && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Handshake qualification of the Moore control vector
    always_comb begin
        ctrl = base_ctrl;
        if (state_q == S_FETCH) begin
            ctrl.ir_write = base_ctrl.ir_write & memReady;
            ctrl.pc_write = base_ctrl.pc_write & memReady;
        end
        if (state_q == S_MEMWR) begin
            ctrl.inst_retired = base_ctrl.inst_retired & memReady;
        end
    end

    assign pcWrite     = ctrl.pc_write;
    assign pcWriteCond = ctrl.pc_write_cond;
    assign iorD        = ctrl.ior_d;
    assign memRead     = ctrl.mem_read;
    assign memWrite    = ctrl.mem_write;
    assign irWrite     = ctrl.ir_write;
    assign memToReg    = ctrl.mem_to_reg;
    assign regDst      = ctrl.reg_dst;
    assign regWrite    = ctrl.reg_write;
    assign aluSrcA     = ctrl.alu_src_a;
    assign aluSrcB     = ctrl.alu_src_b;
    assign aluOp       = ctrl.alu_op;
    assign pcSource    = ctrl.pc_source;
    assign instRetired = ctrl.inst_retired;
    assign illegalOp   = illegal;
    assign memTimeout  = timeout_hit;
    assign state       = state_q;

endmodule

// File: tb/tb_multicycle_ctr.sv
// tb/tb_multicycle_ctr.sv - self-checking bench for multicycle_ctr
module tb_multicycle_ctr;
    import multicycle_ctr_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] opCode;
    logic       zero;
    logic       memReady;
    logic       pcWrite, pcWriteCond, iorD, memRead, memWrite, irWrite;
    logic       memToReg, regDst, regWrite, aluSrcA;
    logic [1:0] aluSrcB, aluOp, pcSource;
    logic       instRetired, illegalOp, memTimeout;
    logic [3:0] state;

    always #5 clk = ~clk;

    multicycle_ctr #(.TIMEOUT(16), .CNT_W(5)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .opCode      (opCode),
        .zero        (zero),
        .memReady    (memReady),
        .pcWrite     (pcWrite),
        .pcWriteCond (pcWriteCond),
        .iorD        (iorD),
        .memRead     (memRead),
        .memWrite    (memWrite),
        .irWrite     (irWrite),
        .memToReg    (memToReg),
        .regDst      (regDst),
        .regWrite    (regWrite),
        .aluSrcA     (aluSrcA),
        .aluSrcB     (aluSrcB),
        .aluOp       (aluOp),
        .pcSource    (pcSource),
        .instRetired (instRetired),
        .illegalOp   (illegalOp),
        .memTimeout  (memTimeout),
        .state       (state)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [16:0] act_vec;
    assign act_vec = {pcWrite, pcWriteCond, iorD, memRead, memWrite, irWrite, memToReg,
                      regDst, regWrite, aluSrcA, aluSrcB, aluOp, pcSource, instRetired};

    // Reference control vector, same bit order as act_vec
    function automatic logic [16:0] model(input logic [3:0] st, input logic mr);
        logic pw, pwc, iord, mrd, mwr, irw, m2r, rdst, rw, asa, ret;
        logic [1:0] asb, aop, pcs;
        {pw, pwc, iord, mrd, mwr, irw, m2r, rdst, rw, asa, ret} = '0;
        asb = 2'b00; aop = 2'b00; pcs = 2'b00;
        case (st)
            4'd1:  begin mrd = 1'b1; asb = 2'b01; irw = mr; pw = mr; end
            4'd2:  begin asb = 2'b11; end
            4'd3:  begin asa = 1'b1; asb = 2'b10; end
            4'd4:  begin mrd = 1'b1; iord = 1'b1; end
            4'd5:  begin rw = 1'b1; m2r = 1'b1; ret = 1'b1; end
            4'd6:  begin mwr = 1'b1; iord = 1'b1; ret = mr; end
            4'd7:  begin asa = 1'b1; aop = 2'b10; end
            4'd8:  begin rw = 1'b1; rdst = 1'b1; ret = 1'b1; end
            4'd9:  begin rw = 1'b1; ret = 1'b1; end
            4'd10: begin asa = 1'b1; aop = 2'b01; pwc = 1'b1; pcs = 2'b01; ret = 1'b1; end
            4'd11: begin pw = 1'b1; pcs = 2'b10; ret = 1'b1; end
            default: ;
        endcase
        return {pw, pwc, iord, mrd, mwr, irw, m2r, rdst, rw, asa, asb, aop, pcs, ret};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic chk_ctrl(input string tag);
        chk({tag, "_ctrl"}, 32'(act_vec), 32'(model(state, memReady)));
    endtask

    typedef struct {
        string            name;
        logic [5:0]       op;
        logic             z;
        int               cycles;
        logic [4:0][3:0]  seq;
    } vec_t;

    vec_t vecs[6];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n;
        int retired;
        int bad_rw;

        vecs[0] = '{"rtype", OP_RTYPE, 1'b0, 4, {S_IDLE, S_RWB, S_EXEC, S_DECODE, S_FETCH}};
        vecs[1] = '{"lw",    OP_LW,    1'b0, 5, {S_MEMWB, S_MEMRD, S_MEMADR, S_DECODE, S_FETCH}};
        vecs[2] = '{"sw",    OP_SW,    1'b0, 4, {S_IDLE, S_MEMWR, S_MEMADR, S_DECODE, S_FETCH}};
        vecs[3] = '{"beq",   OP_BEQ,   1'b1, 3, {S_IDLE, S_IDLE, S_BRANCH, S_DECODE, S_FETCH}};
        vecs[4] = '{"j",     OP_J,     1'b0, 3, {S_IDLE, S_IDLE, S_JUMP, S_DECODE, S_FETCH}};
        vecs[5] = '{"addi",  OP_ADDI,  1'b0, 4, {S_IDLE, S_ADDIWB, S_MEMADR, S_DECODE, S_FETCH}};

        // Reset
        rst_n = 1'b0; opCode = 6'd0; zero = 1'b0; memReady = 1'b0;
        repeat (3) tick();
        chk("reset_state", 32'(state), 32'(S_IDLE));
        chk("reset_outs", 32'(act_vec), 32'd0);
        chk("reset_pulses", {30'd0, illegalOp, memTimeout}, 32'd0);
        rst_n = 1'b1;
        settle();
        chk("release_idle", 32'(state), 32'(S_IDLE));
        tick();
        chk("release_fetch", 32'(state), 32'(S_FETCH));
        chk("release_memread", 32'(memRead), 32'd1);

        // Table-driven instruction sequences with memReady held high
        for (int v = 0; v < 6; v++) begin
            memReady = 1'b1;
            opCode   = vecs[v].op;
            zero     = vecs[v].z;
            settle();
            n = 0; retired = 0; bad_rw = 0;
            do begin
                if (n < 5) chk({vecs[v].name, "_state"}, 32'(state), 32'(vecs[v].seq[n]));
                chk_ctrl(vecs[v].name);
                if (instRetired) retired++;
                if (regWrite && !(state == S_RWB || state == S_MEMWB || state == S_ADDIWB)) bad_rw++;
                n++;
                tick();
            end while (state != S_FETCH && n < 10);
            chk({vecs[v].name, "_cycles"}, 32'(n), 32'(vecs[v].cycles));
            chk({vecs[v].name, "_retired"}, 32'(retired), 32'd1);
            chk({vecs[v].name, "_regwrite_scope"}, 32'(bad_rw), 32'd0);
        end

        // lw stalled three cycles in MEMRD
        opCode = OP_LW; memReady = 1'b1;
        settle();
        tick();
        tick();
        chk("lwstall_memadr", 32'(state), 32'(S_MEMADR));
        memReady = 1'b0;
        tick();
        for (int k = 0; k < 4; k++) begin
            if (k == 3) memReady = 1'b1;
            settle();
            chk("lwstall_memrd", 32'(state), 32'(S_MEMRD));
            chk_ctrl("lwstall");
            chk("lwstall_no_timeout", 32'(memTimeout), 32'd0);
            tick();
        end
        chk("lwstall_memwb", 32'(state), 32'(S_MEMWB));
        chk_ctrl("lwstall_wb");
        tick();
        chk("lwstall_back_fetch", 32'(state), 32'(S_FETCH));

        // FETCH timeout after 16 waiting cycles
        opCode = OP_J; memReady = 1'b0;
        settle();
        for (int k = 1; k <= 16; k++) begin
            chk("to_fetch_state", 32'(state), 32'(S_FETCH));
            chk("to_no_irwrite", {30'd0, irWrite, pcWrite}, 32'd0);
            chk("to_pulse", 32'(memTimeout), (k == 16) ? 32'd1 : 32'd0);
            tick();
        end
        chk("to_refetch_state", 32'(state), 32'(S_FETCH));
        // memReady on the final allowed cycle completes normally
        for (int k = 1; k <= 16; k++) begin
            memReady = (k == 16);
            settle();
            chk("late_no_timeout", 32'(memTimeout), 32'd0);
            if (k == 16) chk("late_irwrite", 32'(irWrite), 32'd1);
            tick();
        end
        chk("late_decode", 32'(state), 32'(S_DECODE));
        tick();
        chk("late_jump", 32'(state), 32'(S_JUMP));
        tick();
        chk("late_fetch", 32'(state), 32'(S_FETCH));

        // Illegal opcode
        opCode = 6'b111111; memReady = 1'b1;
        settle();
        tick();
        chk("ill_decode", 32'(state), 32'(S_DECODE));
        chk("ill_pulse", 32'(illegalOp), 32'd1);
        chk("ill_no_effects", {29'd0, regWrite, memWrite, instRetired}, 32'd0);
        tick();
        chk("ill_fetch", 32'(state), 32'(S_FETCH));
        chk("ill_pulse_gone", 32'(illegalOp), 32'd0);

        // Reset during a MEMWR wait
        opCode = OP_SW; memReady = 1'b1;
        settle();
        tick();
        tick();
        memReady = 1'b0;
        tick();
        chk("rstw_memwr", 32'(state), 32'(S_MEMWR));
        chk("rstw_memwrite", 32'(memWrite), 32'd1);
        tick();
        tick();
        chk("rstw_cnt_before", 32'(dut.cnt_q), 32'd2);
        rst_n = 1'b0;
        settle();
        tick();
        chk("rstw_idle", 32'(state), 32'(S_IDLE));
        chk("rstw_outs", 32'(act_vec), 32'd0);
        chk("rstw_cnt_cleared", 32'(dut.cnt_q), 32'd0);
        rst_n = 1'b1; memReady = 1'b1;
        settle();
        tick();
        chk("rstw_resume_fetch", 32'(state), 32'(S_FETCH));
        chk("rstw_resume_memread", 32'(memRead), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
